// File: rtl/data_memory.sv
// Byte-addressable RV32I data memory: byte-lane stores, sign/zero-extended loads with a
// registered one-cycle read port, access fault reporting, and a resettable output bank in the top words.
module data_memory #(
  parameter int DEPTH    = 1024,
  parameter int IO_WORDS = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [2:0]              funct3,
  input  logic [31:0]             address,
  input  logic [31:0]             write_data,
  output logic [31:0]             read_data,
  output logic                    read_valid,
  output logic                    fault,
  output logic [32*IO_WORDS-1:0]  io_out
);

  // Handshake: req_valid qualifies a single-cycle request and there is no ready; every
  // request present at a rising edge is taken at that edge, and loads answer on the next edge.
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] IO_BASE = AW'(DEPTH - IO_WORDS);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] io_q  [IO_WORDS];

  logic [31:0] read_data_q, read_data_d;
  logic        read_valid_q, read_valid_d;
  logic        fault_q, fault_d;

  logic [AW-1:0] word_idx;
  logic          out_of_range, illegal, misaligned, req_fault, in_io;
  logic          do_store, mem_we;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data, io_rd, rd_word, load_val;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign word_idx     = address[AW+1:2];
  assign out_of_range = |address[31:AW+2];
  assign in_io        = (word_idx >= IO_BASE);

  always_comb begin
    case (funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_write;
      default:                illegal = 1'b1;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                 ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
    req_fault  = illegal | misaligned | out_of_range;

    case (funct3[1:0])
      2'b00: begin
        lane_en   = 4'b0001 << address[1:0];
        lane_data = {4{write_data[7:0]}};
      end
      2'b01: begin
        lane_en   = address[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{write_data[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = write_data;
      end
    endcase
  end

  assign do_store = req_valid & req_write & ~req_fault;
  // Array writes are suppressed while reset is held.
  assign mem_we   = do_store & RST_N;

  always_comb begin
    io_rd = '0;
    for (int k = 0; k < IO_WORDS; k++) begin
      if (word_idx == IO_BASE + AW'(k)) io_rd = io_q[k];
    end
  end

  assign rd_word  = in_io ? io_rd : mem_q[word_idx];
  assign byte_sel = rd_word[{address[1:0], 3'b000} +: 8];
  assign half_sel = address[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (funct3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'b0, byte_sel};
      3'b101:  load_val = {16'b0, half_sel};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    read_valid_d = req_valid & ~req_write;
    fault_d      = req_valid & req_fault;
    read_data_d  = read_data_q;
    if (read_valid_d) read_data_d = req_fault ? 32'b0 : load_val;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      for (int k = 0; k < IO_WORDS; k++) io_q[k] <= '0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      fault_q      <= fault_d;
      for (int k = 0; k < IO_WORDS; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (do_store && lane_en[b] && (word_idx == IO_BASE + AW'(k)))
            io_q[k][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && lane_en[b]) mem_q[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
    end
  end

  for (genvar k = 0; k < IO_WORDS; k++) begin : g_io
    assign io_out[32*k +: 32] = io_q[k];
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: byte-level reference model checked every cycle, plus directed
// vectors with hand-computed results for loads, stores, faults, the output bank and reset.
module tb_data_memory;

  localparam int DEPTH     = 1024;
  localparam int IO_WORDS  = 4;
  localparam int IOW       = 32 * IO_WORDS;
  localparam int IO_BASE_B = 4 * (DEPTH - IO_WORDS);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_write;
  logic [2:0]      funct3;
  logic [31:0]     address, write_data;
  logic [31:0]     read_data;
  logic            read_valid, fault;
  logic [IOW-1:0]  io_out;

  int n_vec  = 0;
  int n_fail = 0;

  data_memory #(.DEPTH(DEPTH), .IO_WORDS(IO_WORDS)) dut (
    .CLK(clk), .RST_N(rst_n), .req_valid(req_valid), .req_write(req_write),
    .funct3(funct3), .address(address), .write_data(write_data),
    .read_data(read_data), .read_valid(read_valid), .fault(fault), .io_out(io_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model (byte granular) ----------------
  logic [7:0]  mem_b [int];
  logic [7:0]  io_b  [4*IO_WORDS];
  logic [31:0] exp_rd = '0;
  logic        exp_rv = 1'b0;
  logic        exp_f  = 1'b0;

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_fault(input logic w, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    if (a >= 32'(4 * DEPTH)) return 1'b1;
    if ((a % 32'(acc_size(f3))) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int          sz = acc_size(f3);
    int          ia = int'(a);
    logic [31:0] v  = '0;
    for (int i = 0; i < sz; i++)
      v[8*i +: 8] = (ia >= IO_BASE_B) ? io_b[ia - IO_BASE_B + i] : mem_b[ia + i];
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
    return v;
  endfunction

  function automatic logic [IOW-1:0] model_io();
    logic [IOW-1:0] v = '0;
    for (int j = 0; j < 4*IO_WORDS; j++) v[8*j +: 8] = io_b[j];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit flt;
    if (!rst_n) begin
      exp_rv = 1'b0;
      exp_f  = 1'b0;
      exp_rd = '0;
      for (int j = 0; j < 4*IO_WORDS; j++) io_b[j] = 8'h00;
    end else begin
      exp_rv = 1'b0;
      exp_f  = 1'b0;
      if (req_valid) begin
        flt   = is_fault(req_write, funct3, address);
        exp_f = flt;
        if (!req_write) begin
          exp_rv = 1'b1;
          exp_rd = flt ? 32'h0 : model_load(funct3, address);
        end else if (!flt) begin
          for (int i = 0; i < acc_size(funct3); i++) begin
            mem_b[int'(address) + i] = write_data[8*i +: 8];
            if (int'(address) >= IO_BASE_B) io_b[int'(address) - IO_BASE_B + i] = write_data[8*i +: 8];
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [IOW-1:0] act, input logic [IOW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc read_valid", IOW'(read_valid), IOW'(exp_rv));
    check("cyc fault",      IOW'(fault),      IOW'(exp_f));
    check("cyc read_data",  IOW'(read_data),  IOW'(exp_rd));
    check("cyc io_out",     io_out,           model_io());
  end

  // ---------------- driver tasks ----------------
  task automatic req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; funct3 = f3; address = a; write_data = wd;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic load_check(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v);
    req(1'b0, f3, a, 32'h0);
    idle();
    check({nm, " data"},  IOW'(read_data),  IOW'(v));
    check({nm, " valid"}, IOW'(read_valid), IOW'(1'b1));
    check({nm, " fault"}, IOW'(fault),      IOW'(1'b0));
  endtask

  task automatic fault_check(input string nm, input logic w, input logic [2:0] f3, input logic [31:0] a);
    req(w, f3, a, 32'h1234_5678);
    idle();
    check({nm, " fault"}, IOW'(fault),      IOW'(1'b1));
    check({nm, " valid"}, IOW'(read_valid), IOW'(!w));
    check({nm, " data"},  IOW'(read_data),  IOW'(32'h0));
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: run did not complete");
    summary();
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    funct3 = 3'b0; address = '0; write_data = '0;
    #7;
    check("rst read_data",  IOW'(read_data),  '0);
    check("rst read_valid", IOW'(read_valid), '0);
    check("rst fault",      IOW'(fault),      '0);
    check("rst io_out",     io_out,           '0);
    @(negedge clk); #1 rst_n = 1'b1;

    // widths and extension
    req(1'b1, 3'b010, 32'h10, 32'h8000_00F1);
    load_check("LB 0x10",  3'b000, 32'h10, 32'hFFFF_FFF1);
    load_check("LBU 0x10", 3'b100, 32'h10, 32'h0000_00F1);
    load_check("LH 0x10",  3'b001, 32'h10, 32'h0000_00F1);
    load_check("LHU 0x10", 3'b101, 32'h10, 32'h0000_00F1);
    load_check("LW 0x10",  3'b010, 32'h10, 32'h8000_00F1);
    idle();
    check("hold valid", IOW'(read_valid), '0);
    check("hold data",  IOW'(read_data),  IOW'(32'h8000_00F1));

    // byte lanes
    req(1'b1, 3'b010, 32'h20, 32'h1122_3344);
    req(1'b1, 3'b000, 32'h22, 32'h0000_00AA);
    req(1'b1, 3'b001, 32'h20, 32'h0000_BEEF);
    load_check("lanes LW 0x20", 3'b010, 32'h20, 32'h11AA_BEEF);
    load_check("LH 0x22",       3'b001, 32'h22, 32'h0000_11AA);
    load_check("LB 0x22",       3'b000, 32'h22, 32'hFFFF_FFAA);

    // faults
    fault_check("LW misaligned", 1'b0, 3'b010, 32'h21);
    fault_check("SH misaligned", 1'b1, 3'b001, 32'h23);
    fault_check("LW out of range", 1'b0, 3'b010, 32'(4 * DEPTH));
    fault_check("funct3 011", 1'b0, 3'b011, 32'h20);
    fault_check("SB funct3 100", 1'b1, 3'b100, 32'h20);
    load_check("after faults LW 0x20", 3'b010, 32'h20, 32'h11AA_BEEF);

    // back-to-back loads
    req(1'b0, 3'b010, 32'h10, 32'h0);
    req(1'b0, 3'b010, 32'h20, 32'h0);
    check("b2b 1 data",  IOW'(read_data),  IOW'(32'h8000_00F1));
    check("b2b 1 valid", IOW'(read_valid), IOW'(1'b1));
    req(1'b0, 3'b010, 32'h10, 32'h0);
    check("b2b 2 data",  IOW'(read_data),  IOW'(32'h11AA_BEEF));
    check("b2b 2 valid", IOW'(read_valid), IOW'(1'b1));
    idle();
    check("b2b 3 data",  IOW'(read_data),  IOW'(32'h8000_00F1));
    check("b2b 3 valid", IOW'(read_valid), IOW'(1'b1));
    idle();
    check("b2b drop valid", IOW'(read_valid), '0);

    // output bank
    load_check("IO LW reset value", 3'b010, 32'(4 * (DEPTH - 1)), 32'h0);
    req(1'b1, 3'b010, 32'(4 * (DEPTH - 1)), 32'hCAFE_0001);
    idle();
    check("IO word after SW", io_out, {32'hCAFE_0001, 96'h0});
    req(1'b1, 3'b000, 32'(IO_BASE_B + 1), 32'h0000_005A);
    idle();
    check("IO word0 after SB", io_out, {32'hCAFE_0001, 64'h0, 32'h0000_5A00});
    load_check("IO LW readback", 3'b010, 32'(4 * (DEPTH - 1)), 32'hCAFE_0001);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async rst io_out", io_out,            '0);
    check("async rst data",   IOW'(read_data),   '0);
    check("async rst valid",  IOW'(read_valid),  '0);
    @(negedge clk); #1 rst_n = 1'b1;

    // load overtaken by reset
    req(1'b0, 3'b010, 32'h10, 32'h0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst drop valid", IOW'(read_valid), '0);
    check("rst drop data",  IOW'(read_data),  '0);
    @(negedge clk); #1 rst_n = 1'b1;
    idle();
    check("post rst valid", IOW'(read_valid), '0);
    check("post rst data",  IOW'(read_data),  '0);
    load_check("array kept LW 0x10", 3'b010, 32'h10, 32'h8000_00F1);
    load_check("IO cleared LW", 3'b010, 32'(4 * (DEPTH - 1)), 32'h0);
    idle();

    summary();
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Parametrised byte-addressable data memory for the RISC-V core, replacing the word-only RAM on the load/store path. It supports all RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) through byte lanes and sign/zero extension, and returns read data through a registered, one-cycle-latency port for the pipelined datapath. It flags misaligned, out-of-range and illegal accesses. The top `IO_WORDS` words form a resettable memory-mapped output bank exported to board I/O.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two, ≥ 2·`IO_WORDS`.
- `IO_WORDS`, 4: number of words at the top of memory mapped to resettable output registers; ≥ 1.
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  access request this cycle.
- `req_write`  in  1  1 = store, 0 = load; ignored when `req_valid`=0.
- `funct3`  in  3  RV32I load/store funct3.
- `address`  in  32  byte address.
- `write_data`  in  32  store data; the low byte/halfword is used for SB/SH.
- `read_data`  out  32  extended load result, registered.
- `read_valid`  out  1  `read_data` valid; one-cycle pulse.
- `fault`  out  1  previous-cycle request rejected; one-cycle pulse.
- `io_out`  out  32·`IO_WORDS`  output bank; word k is at bits [32k+31:32k].

## Operation
- Word index = `address`[log2(DEPTH)+1:2]. The access is out of range if any `address` bit above log2(DEPTH)+1 is set.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Misaligned: halfword access with `address`[0]=1, or word access with `address`[1:0]≠00.
- A faulting request (illegal, misaligned or out of range) is not performed. Nothing is written, `read_data` becomes 0, and `fault` pulses next cycle. For a faulting load, `read_valid` also pulses.
- Store byte lanes:
  - SB writes lane `address`[1:0].
  - SH writes lanes {1,0} if `address`[1]=0, else lanes {3,2}.
  - SW writes all four lanes.
  - Unwritten lanes keep their value.
- Load extraction:
  - LB/LBU select byte `address`[1:0].
  - LH/LHU select halfword `address`[1].
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
- IO region, word indices `DEPTH-IO_WORDS` … `DEPTH-1`:
  - Stores update both the array word and `io_out` word (index − (`DEPTH-IO_WORDS`)) with the same byte lanes.
  - Loads return the `io_out` register, so the reset value 0 is readable.
- The array has no reset; its contents are undefined until written. `io_out` registers reset to 0.

## Timing
- Reset (`RST_N`=0, asynchronous):
  - `read_data`=0, `read_valid`=0, `fault`=0, all `io_out`=0.
  - No array writes occur while in reset.
  - A load accepted in the cycle reset asserts is discarded; no `read_valid` follows.
- Load accepted at edge N: `read_data`, `read_valid`=1 (and `fault` if faulting) are valid after edge N+1. `read_valid` drops after edge N+2 unless another load is accepted at N+1.
- Back-to-back loads are accepted every cycle with full throughput and no stall.
- Store accepted at edge N: the array and `io_out` are updated at edge N+1.
- A load of the same address accepted at edge N+1 returns the new data at N+2. No forwarding is needed or allowed within a single edge.
- `read_data` holds its last value while `read_valid`=0. Stores do not change `read_data` or `read_valid`. A faulting store pulses `fault` only.
- `req_valid`=0: no state changes except `read_valid` and `fault` returning to 0.

## Test plan
- SW 0x8000_00F1 to 0x10, then LB, LBU, LH, LHU, LW at 0x10 → 0xFFFF_FFF1, 0x0000_00F1, 0x0000_00F1, 0x0000_00F1, 0x8000_00F1. Each arrives one cycle after its request with `read_valid`=1.
- SW 0x1122_3344 to 0x20, SB 0xAA at 0x22, SH 0xBEEF at 0x20, then LW 0x20 → 0x11AA_BEEF.
- Misaligned LW at 0x21, SH at 0x23, out-of-range LW at 4·`DEPTH`, and funct3=011 → `fault` pulses. Loads return 0 with `read_valid`=1. A following LW 0x20 still returns 0x11AA_BEEF.
- After reset, LW at word `DEPTH-1` → 0. SW 0xCAFE_0001 there → `io_out` word `IO_WORDS-1` = 0xCAFE_0001 after one edge. Asserting `RST_N`=0 clears it to 0 immediately, without waiting for a clock edge.
- Loads to 0x10, 0x20, 0x10 on consecutive cycles → three consecutive `read_valid` cycles with the correct data in order.
- Load accepted, then `RST_N` pulsed low before the next edge → `read_valid` stays 0 and `read_data`=0.
